root_port_unit: RTL

//  Parametrised local-port interface of the root node, successor to the fixed
//  two-source root output path. Round-robin arbitrates NUM_SRC tx sources onto
//  the root quadtree router LOCAL input with credit flow control. Steers inbound

---
 rtl/root_port_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/root_port_unit.sv
// Root-node local port: round-robin tx arbitration onto the router with credit
// flow control, read-response FIFO on the rx side, and upstream credit return.
module root_port_unit #(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned TYPE_W        = 2,
    parameter int unsigned RD_TYPE       = 2,
    parameter int unsigned RD_WIDTH      = 32,
    parameter int unsigned CREDIT_DEPTH  = 4,
    parameter int unsigned RD_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_tx_en,
    input  logic [NUM_SRC*WIDTH-1:0]   src_tx_data,
    output logic [NUM_SRC-1:0]         src_tx_rdy,
    output logic                       router_rdy,
    output logic                       out_data_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       downstream_credit,
    input  logic                       in_data_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       upstream_credit,
    output logic                       read_data_vld,
    input  logic                       read_data_rdy,
    output logic [RD_WIDTH-1:0]        read_data,
    output logic                       rd_overflow
);

    localparam int unsigned PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CRD_W  = $clog2(CREDIT_DEPTH + 1);
    localparam int unsigned FA_W   = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int unsigned FC_W   = $clog2(RD_FIFO_DEPTH + 1);
    // Owed credits stay bounded by FIFO occupancy plus in-flight returns.
    localparam int unsigned PEND_W = $clog2(RD_FIFO_DEPTH + CREDIT_DEPTH + 2) + 1;

    logic [CRD_W-1:0]    credit_cnt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic                accept;

    logic [RD_WIDTH-1:0] mem [RD_FIFO_DEPTH];
    logic [FA_W-1:0]     wr_ptr;
    logic [FA_W-1:0]     rd_ptr;
    logic [FC_W-1:0]     fifo_cnt;
    logic                is_rd;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                rx_other;

    logic [PEND_W-1:0]   pend_cnt;
    logic [PEND_W-1:0]   pend_sum;
    logic                emit;

    function automatic logic [FA_W-1:0] ptr_inc(input logic [FA_W-1:0] p);
        return (p == FA_W'(RD_FIFO_DEPTH - 1)) ? '0 : p + FA_W'(1);
    endfunction

    // Round-robin grant: first requester at or after rr_ptr, only with credit.
    always_comb begin
        src_tx_rdy = '0;
        grant_idx  = '0;
        accept     = 1'b0;
        cand       = '0;
        if (credit_cnt != '0) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                cand = PTR_W'((32'(rr_ptr) + k) % NUM_SRC);
                if (!accept && src_tx_en[cand]) begin
                    accept    = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (accept) begin
            src_tx_rdy[grant_idx] = 1'b1;
        end
    end

    assign router_rdy = (credit_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_valid <= 1'b0;
            out_data       <= '0;
            rr_ptr         <= '0;
        end else begin
            out_data_valid <= accept;
            if (accept) begin
                out_data <= src_tx_data[32'(grant_idx)*WIDTH +: WIDTH];
                rr_ptr   <= PTR_W'((32'(grant_idx) + 1) % NUM_SRC);
            end
        end
    end

    // Coincident accept and return cancel; a return at full credit is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CRD_W'(CREDIT_DEPTH);
        end else if (accept && !downstream_credit) begin
            credit_cnt <= credit_cnt - CRD_W'(1);
        end else if (!accept && downstream_credit &&
                     credit_cnt != CRD_W'(CREDIT_DEPTH)) begin
            credit_cnt <= credit_cnt + CRD_W'(1);
        end
    end

    credit_overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(downstream_credit && !accept && credit_cnt == CRD_W'(CREDIT_DEPTH)))
        else $error("downstream credit returned while credit count is full");

    assign is_rd         = in_data_valid && (in_data[WIDTH-1 -: TYPE_W] == TYPE_W'(RD_TYPE));
    assign read_data_vld = (fifo_cnt != '0);
    assign pop           = read_data_vld && read_data_rdy;
    assign fifo_full     = (fifo_cnt == FC_W'(RD_FIFO_DEPTH));
    assign push          = is_rd && (!fifo_full || pop);
    assign drop          = is_rd && fifo_full && !pop;
    assign rx_other      = in_data_valid && !is_rd;
    assign read_data     = mem[rd_ptr];

    // First-word fall-through read FIFO; head is always visible on read_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rd_overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data[RD_WIDTH-1:0];
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + FC_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - FC_W'(1);
            end
            if (drop) begin
                rd_overflow <= 1'b1;
            end
        end
    end

    // Credits due this cycle join the owed pool; one pulse leaves per cycle.
    always_comb begin
        pend_sum = pend_cnt + PEND_W'(rx_other) + PEND_W'(pop) + PEND_W'(drop);
        emit     = (pend_sum != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt        <= '0;
            upstream_credit <= 1'b0;
        end else begin
            pend_cnt        <= pend_sum - PEND_W'(emit);
            upstream_credit <= emit;
        end
    end

    generate
        if (WIDTH - TYPE_W > RD_WIDTH) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^in_data[WIDTH-TYPE_W-1:RD_WIDTH];
        end
    endgenerate

endmodule
